// File: rtl/ila_dump.sv
// ila_dump: reads the ila_core sample buffer one DATA_W word at a time and streams
// it out over a valid/ready port, sample-major and word-minor, with last/done framing.
module ila_dump #(
  parameter  int DATA_W   = 32,
  parameter  int BUFFER_W = 8,
  parameter  int SIGNAL_W = 8,
  localparam int WORDS    = (SIGNAL_W + DATA_W - 1) / DATA_W,
  localparam int SEL_W    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [BUFFER_W-1:0] samples,
  output logic [BUFFER_W-1:0] index,
  output logic [SEL_W-1:0]    value_select,
  input  logic [DATA_W-1:0]   value,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_CAPTURE, S_SEND} state_t;

  localparam logic [SEL_W-1:0] LAST_WORD = SEL_W'(WORDS - 1);

  state_t              r_state;
  state_t              w_next;
  logic [BUFFER_W-1:0] r_n;
  logic [BUFFER_W-1:0] r_sample_cnt;
  logic [SEL_W-1:0]    r_word_cnt;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_busy;
  logic                r_done;

  logic w_start_ok;
  logic w_zero_start;
  logic w_abort;
  logic w_accept;
  logic w_final;

  // A simultaneous abort cancels a start in IDLE and an acceptance in SEND.
  assign w_start_ok   = (r_state == S_IDLE) && start && !abort;
  assign w_zero_start = w_start_ok && (samples == '0);
  assign w_abort      = (r_state != S_IDLE) && abort;
  assign w_accept     = (r_state == S_SEND) && r_out_valid && out_ready && !abort;
  assign w_final      = (r_word_cnt == LAST_WORD) && (r_sample_cnt == r_n - BUFFER_W'(1));

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_start_ok && !w_zero_start) w_next = S_ADDR;
      S_ADDR:    w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_SEND;
      S_SEND:    if (w_accept) w_next = w_final ? S_IDLE : S_ADDR;
      default:   w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_n          <= '0;
      r_sample_cnt <= '0;
      r_word_cnt   <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_n          <= samples;
        r_sample_cnt <= '0;
        r_word_cnt   <= '0;
      end
      if (w_accept) begin
        if (r_word_cnt == LAST_WORD) begin
          r_word_cnt   <= '0;
          r_sample_cnt <= r_sample_cnt + BUFFER_W'(1);
        end else begin
          r_word_cnt <= r_word_cnt + SEL_W'(1);
        end
      end
      if (r_state == S_CAPTURE && !w_abort) begin
        r_out_data  <= value;
        r_out_valid <= 1'b1;
        r_out_last  <= w_final;
      end
      if (w_accept || w_abort) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      // An empty dump still shows one busy cycle alongside its done pulse.
      r_busy <= (w_next != S_IDLE) || w_zero_start;
      r_done <= w_abort || (w_accept && w_final) || w_zero_start;
    end
  end

  assign index        = r_sample_cnt;
  assign value_select = r_word_cnt;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign out_last     = r_out_last;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_ila_dump.sv
// tb_ila_dump: two ila_dump instances (1 word and 4 words per sample) with ila_core
// read models; a scoreboard queue per instance is checked by a negedge monitor.
module tb_ila_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s  [2];
  logic        abort_s  [2];
  logic        ready_s  [2];
  logic [7:0]  samples_s[2];
  logic [7:0]  index_s  [2];
  logic [31:0] value_s  [2];
  logic [31:0] data_s   [2];
  logic        valid_s  [2];
  logic        last_s   [2];
  logic        busy_s   [2];
  logic        done_s   [2];
  logic [0:0]  vsel_a;
  logic [1:0]  vsel_b;

  always #5 clk = ~clk;

  ila_dump #(.DATA_W(32), .BUFFER_W(8), .SIGNAL_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]), .samples(samples_s[0]),
    .index(index_s[0]), .value_select(vsel_a), .value(value_s[0]), .out_data(data_s[0]),
    .out_valid(valid_s[0]), .out_ready(ready_s[0]), .out_last(last_s[0]),
    .busy(busy_s[0]), .done(done_s[0])
  );

  ila_dump #(.DATA_W(32), .BUFFER_W(8), .SIGNAL_W(128)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]), .samples(samples_s[1]),
    .index(index_s[1]), .value_select(vsel_b), .value(value_s[1]), .out_data(data_s[1]),
    .out_valid(valid_s[1]), .out_ready(ready_s[1]), .out_last(last_s[1]),
    .busy(busy_s[1]), .done(done_s[1])
  );

  // ila_core read port: one cycle from address to word.
  always @(posedge clk) begin
    value_s[0] <= 32'(index_s[0]) + 32'h10;
    value_s[1] <= {16'h0, index_s[1], 6'h0, vsel_b};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int valid_cnt[2] = '{0, 0};
  int acc_cnt  [2] = '{0, 0};
  int acc_cyc  [2] = '{0, 0};
  int done_cyc [2] = '{0, 0};
  int dbase[2], abase[2], bbase[2], vbase[2];
  int start_cyc;
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [32:0] q_pop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic q_push(input int d, input logic [32:0] e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic q_clear(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  // Reference: instance 0 returns index+0x10, instance 1 returns {index, select}.
  function automatic logic [31:0] model(input int d, input int s, input int w);
    if (d == 0) return 32'(s + 16);
    return 32'((s << 8) | w);
  endfunction

  // Monitor: scoreboard pops on every transfer, plus hold-stability while stalled.
  logic        hold     [2] = '{1'b0, 1'b0};
  logic [31:0] hold_data[2];
  logic        hold_last[2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        hold[d] = 1'b0;
      end else begin
        if (busy_s[d])  busy_cnt[d]++;
        if (valid_s[d]) valid_cnt[d]++;
        if (done_s[d]) begin
          done_cnt[d]++;
          done_cyc[d] = cyc;
        end
        if (hold[d])
          check(d == 0 ? "stall_hold_a" : "stall_hold_b",
                {valid_s[d], last_s[d], data_s[d]}, {1'b1, hold_last[d], hold_data[d]});
        if (valid_s[d] && ready_s[d] && !abort_s[d]) begin
          if (q_size(d) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_word dut%0d: got 0x%0h expected no word", d, data_s[d]);
          end else begin
            check(d == 0 ? "word_a" : "word_b", {last_s[d], data_s[d]}, q_pop(d));
          end
          acc_cnt[d]++;
          acc_cyc[d] = cyc;
        end
        hold[d]      = valid_s[d] && !ready_s[d] && !abort_s[d];
        hold_data[d] = data_s[d];
        hold_last[d] = last_s[d];
      end
    end
  end

  task automatic issue(input int d, input int n);
    int words = (d == 0) ? 1 : 4;
    for (int s = 0; s < n; s++)
      for (int w = 0; w < words; w++)
        q_push(d, {(s == n - 1) && (w == words - 1), model(d, s, w)});
    dbase[d] = done_cnt[d];
    abase[d] = acc_cnt[d];
    bbase[d] = busy_cnt[d];
    vbase[d] = valid_cnt[d];
    samples_s[d] = 8'(n);
    start_s[d]   = 1'b1;
    start_cyc    = cyc;
    @(posedge clk); #1;
    start_s[d]   = 1'b0;
    samples_s[d] = 8'($urandom);
  endtask

  task automatic run_until_done(input int d, input int rmode, input int budget);
    int k = 0;
    while (done_cnt[d] == dbase[d] && k < budget) begin
      ready_s[d] = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    check("done_once", done_cnt[d] - dbase[d], 1);
    check("scoreboard_drained", q_size(d), 0);
    check("idle_after_done", {busy_s[d], valid_s[d], last_s[d]}, 0);
  endtask

  task automatic wait_acc(input int d, input int target, input int budget);
    int k = 0;
    while (acc_cnt[d] - abase[d] < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_acc_in_time", k < budget, 1);
  endtask

  task automatic wait_valid(input int d, input int budget);
    int k = 0;
    while (!valid_s[d] && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_valid_in_time", k < budget, 1);
  endtask

  initial begin
    int d, n, b0, d0;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; ready_s[i] = 1'b0; samples_s[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_a", {index_s[0], vsel_a, data_s[0], valid_s[0], last_s[0], busy_s[0], done_s[0]}, 0);
    check("reset_outputs_b", {index_s[1], vsel_b, data_s[1], valid_s[1], last_s[1], busy_s[1], done_s[1]}, 0);
    @(posedge clk); #1;

    // Three one-word samples, start on the first edge after reset release.
    rst = 1'b1;
    ready_s[0] = 1'b1;
    issue(0, 3);
    check("first_start_busy", busy_s[0], 1);
    run_until_done(0, 0, 200);
    check("start_to_last_accept", acc_cyc[0] - start_cyc, 9);
    check("done_after_last", done_cyc[0] - acc_cyc[0], 1);

    // Four words per sample.
    ready_s[1] = 1'b1;
    issue(1, 2);
    run_until_done(1, 0, 200);
    check("wide_word_count", acc_cnt[1] - abase[1], 8);

    // Empty dump.
    issue(0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("empty_no_valid", valid_cnt[0] - vbase[0], 0);
    check("empty_busy_cycles", busy_cnt[0] - bbase[0], 1);
    check("empty_done_pulses", done_cnt[0] - dbase[0], 1);

    // start together with abort in IDLE is ignored.
    b0 = busy_cnt[0]; d0 = done_cnt[0];
    start_s[0] = 1'b1; abort_s[0] = 1'b1; samples_s[0] = 8'd3;
    @(posedge clk); #1;
    start_s[0] = 1'b0; abort_s[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("start_abort_no_busy", busy_cnt[0] - b0, 0);
    check("start_abort_no_done", done_cnt[0] - d0, 0);

    // Stall on word 1 for five cycles, then random backpressure.
    ready_s[0] = 1'b1;
    issue(0, 4);
    wait_acc(0, 1, 50);
    ready_s[0] = 1'b0;
    wait_valid(0, 50);
    repeat (5) @(posedge clk);
    #1;
    check("stalled_word", {valid_s[0], data_s[0]}, {1'b1, 32'h11});
    run_until_done(0, 1, 400);
    check("stall_word_count", acc_cnt[0] - abase[0], 4);

    // Abort on the second word in SEND while ready is high.
    ready_s[0] = 1'b1;
    issue(0, 4);
    wait_acc(0, 1, 50);
    wait_valid(0, 50);
    abort_s[0] = 1'b1;
    @(posedge clk); #1;
    abort_s[0] = 1'b0;
    check("abort_outputs", {valid_s[0], last_s[0], done_s[0], busy_s[0]}, 4'b0010);
    check("abort_delivered", acc_cnt[0] - abase[0], 1);
    @(posedge clk); #1;
    check("abort_idle", {busy_s[0], done_s[0]}, 0);
    check("abort_done_pulses", done_cnt[0] - dbase[0], 1);
    check("abort_left_in_queue", q_size(0), 3);
    q_clear(0);

    // Reset in the middle of a dump.
    issue(0, 4);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {index_s[0], vsel_a, data_s[0], valid_s[0], last_s[0], busy_s[0], done_s[0]}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_no_done", done_cnt[0] - dbase[0], 0);
    q_clear(0);
    issue(0, 1);
    run_until_done(0, 0, 100);
    check("post_reset_words", acc_cnt[0] - abase[0], 1);

    // Random dumps with random backpressure on both instances.
    for (int it = 0; it < 8; it++) begin
      d = $urandom_range(0, 1);
      n = $urandom_range(1, 6);
      issue(d, n);
      run_until_done(d, 1, 2000);
      check("random_word_count", acc_cnt[d] - abase[d], n * ((d == 0) ? 1 : 4));
    end

    // Largest sample count.
    issue(0, 255);
    run_until_done(0, 1, 6000);
    check("max_word_count", acc_cnt[0] - abase[0], 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
